// File: rtl/wb_bus_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// wb_bus_ctrl_pkg
// Shared definitions for the registered Wishbone interconnect:
//   - FSM state encodings (IDLE/BUSY/RESP)
//   - one-hot slave select address bits (SPI_RAM_BIT .. SPI_BIT)
//   - default error read data
//   - saturating increment helper for the optional error log
// No ports (package).
// ----------------------------------------------------------------------------
package wb_bus_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Slave i is selected by address bit (SPI_RAM_BIT - i).
   localparam int SPI_RAM_BIT = 31;
   localparam int ROM_BIT     = 30;
   localparam int UART_BIT    = 29;
   localparam int GPIO_BIT    = 28;
   localparam int TIMER_BIT   = 27;
   localparam int SPI_BIT     = 26;

   localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : (v + 16'd1);
   endfunction

endpackage

// File: rtl/wb_bus_timeout.sv
// ----------------------------------------------------------------------------
// wb_bus_timeout
// Cycle counter that bounds how long the bus waits for a slave ACK.
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   clr_i        synchronous clear to zero (has priority over en_i)
//   en_i         count up by one per cycle
//   expired_o    counter equals TIMEOUT while enabled
// ----------------------------------------------------------------------------
module wb_bus_timeout #(
   parameter int TIMEOUT = 1023,
   parameter int TO_W    = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   logic [TO_W-1:0] cnt_q, cnt_d;

   // Next count: clear wins, otherwise increment while enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The owner leaves BUSY on expiry, so the count never passes TIMEOUT.
   assign expired_o = en_i && (cnt_q == TO_W'(TIMEOUT));

endmodule

// File: rtl/wb_bus_ctrl.sv
// ----------------------------------------------------------------------------
// wb_bus_ctrl
// Registered Wishbone interconnect between one master and NS slaves.
// A request in IDLE is decoded by one-hot address bits (lowest slave index
// wins), forwarded in BUSY, and answered with a single-cycle registered
// ACK in RESP. Unmapped addresses and ACK timeouts return an error response
// carrying ERR_DATA.
// Ports:
//   clk, rst_n                       clock / async active-low reset
//   m_cyc_i, m_stb_i, m_we_i,
//   m_sel_i, m_adr_i, m_dat_i        master request
//   m_ack_o, m_err_o, m_dat_o        registered master response
//   s_cyc_o                          per-slave cycle (one-hot or zero)
//   s_stb_o                          m_stb_i gated by BUSY
//   s_we_o, s_sel_o, s_adr_o, s_dat_o broadcast master signals
//   s_ack_i, s_dat_i                 per-slave ACK / read data
// Optional feature macro: WB_BUS_ERRLOG_EN
//   adds err_cnt_o (saturating error count) and err_adr_o (last error address)
// ----------------------------------------------------------------------------
module wb_bus_ctrl
   import wb_bus_ctrl_pkg::*;
#(
   parameter int          NS       = 6,
   parameter int          SEL_MSB  = SPI_RAM_BIT,
   parameter int          TIMEOUT  = 1023,
   parameter int          TO_W     = 10,
   parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             m_cyc_i,
   input  logic             m_stb_i,
   input  logic             m_we_i,
   input  logic [3:0]       m_sel_i,
   input  logic [31:0]      m_adr_i,
   input  logic [31:0]      m_dat_i,
   output logic             m_ack_o,
   output logic             m_err_o,
   output logic [31:0]      m_dat_o,
   output logic [NS-1:0]    s_cyc_o,
   output logic             s_stb_o,
   output logic             s_we_o,
   output logic [3:0]       s_sel_o,
   output logic [31:0]      s_adr_o,
   output logic [31:0]      s_dat_o,
   input  logic [NS-1:0]    s_ack_i,
   input  logic [NS*32-1:0] s_dat_i
`ifdef WB_BUS_ERRLOG_EN
   ,
   output logic [15:0]      err_cnt_o,
   output logic [31:0]      err_adr_o
`endif
);

   localparam int IDX_W = (NS > 1) ? $clog2(NS) : 1;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             ack_q, ack_d;
   logic             err_q, err_d;
   logic [31:0]      dat_q, dat_d;

   logic             hit_s;
   logic [IDX_W-1:0] hit_idx_s;
   logic             sel_ack_s;
   logic [31:0]      sel_dat_s;
   logic             busy_s;
   logic             to_exp_s;
   logic [NS-1:0]    s_cyc_s;

   assign busy_s = (state_q == ST_BUSY);

   // Priority decode: scanning downward leaves the lowest set index.
   always_comb begin
      hit_s     = 1'b0;
      hit_idx_s = '0;
      for (int i = NS - 1; i >= 0; i--) begin
         hit_s     = hit_s | m_adr_i[SEL_MSB-i];
         hit_idx_s = m_adr_i[SEL_MSB-i] ? IDX_W'(i) : hit_idx_s;
      end
   end

   assign sel_ack_s = s_ack_i[idx_q];
   assign sel_dat_s = s_dat_i[32*int'(idx_q) +: 32];

   wb_bus_timeout #(
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) u_timeout (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (!busy_s),
      .en_i      (busy_s),
      .expired_o (to_exp_s)
   );

   // FSM next state and response register inputs.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      dat_d   = dat_q;
      case (state_q)
         ST_IDLE: begin
            if (m_cyc_i && m_stb_i) begin
               if (hit_s) begin
                  idx_d   = hit_idx_s;
                  state_d = ST_BUSY;
               end else begin
                  state_d = ST_RESP;
                  ack_d   = 1'b1;
                  err_d   = 1'b1;
                  dat_d   = ERR_DATA;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            // Abort beats ACK; ACK beats timeout.
            if (!m_cyc_i) begin
               state_d = ST_IDLE;
            end else if (sel_ack_s) begin
               state_d = ST_RESP;
               ack_d   = 1'b1;
               dat_d   = sel_dat_s;
            end else if (to_exp_s) begin
               state_d = ST_RESP;
               ack_d   = 1'b1;
               err_d   = 1'b1;
               dat_d   = ERR_DATA;
            end else begin
               state_d = ST_BUSY;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         dat_q   <= 32'h0000_0000;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         dat_q   <= dat_d;
      end
   end

   // Slave cycle follows m_cyc_i directly so an abort drops it the same cycle.
   always_comb begin
      s_cyc_s = '0;
      if (busy_s) begin
         s_cyc_s[idx_q] = m_cyc_i;
      end else begin
         s_cyc_s = '0;
      end
   end

   assign m_ack_o = ack_q;
   assign m_err_o = err_q;
   assign m_dat_o = dat_q;
   assign s_cyc_o = s_cyc_s;
   assign s_stb_o = m_stb_i & busy_s;
   assign s_we_o  = m_we_i;
   assign s_sel_o = m_sel_i;
   assign s_adr_o = m_adr_i;
   assign s_dat_o = m_dat_i;

`ifdef WB_BUS_ERRLOG_EN
   logic [15:0] err_cnt_q, err_cnt_d;
   logic [31:0] err_adr_q, err_adr_d;

   // err_d is only ever set on the transition into RESP.
   always_comb begin
      err_cnt_d = err_cnt_q;
      err_adr_d = err_adr_q;
      if (err_d) begin
         err_cnt_d = sat_inc16(err_cnt_q);
         err_adr_d = m_adr_i;
      end else begin
         err_cnt_d = err_cnt_q;
         err_adr_d = err_adr_q;
      end
   end

   // Error log registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_q <= 16'h0000;
         err_adr_q <= 32'h0000_0000;
      end else begin
         err_cnt_q <= err_cnt_d;
         err_adr_q <= err_adr_d;
      end
   end

   assign err_cnt_o = err_cnt_q;
   assign err_adr_o = err_adr_q;
`endif

endmodule

// File: tb/tb_wb_bus_ctrl.sv
// ----------------------------------------------------------------------------
// tb_wb_bus_ctrl
// Self-checking bench for wb_bus_ctrl: directed vector table, hand-written
// abort/reset sequences and randomized transactions against a
// cycle-count model of the interconnect.
// ----------------------------------------------------------------------------
module tb_wb_bus_ctrl;

   localparam int NS      = 6;
   localparam int TIMEOUT = 12;
   localparam int TO_W    = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             m_cyc_i, m_stb_i, m_we_i;
   logic [3:0]       m_sel_i;
   logic [31:0]      m_adr_i, m_dat_i;
   logic             m_ack_o, m_err_o;
   logic [31:0]      m_dat_o;
   logic [NS-1:0]    s_cyc_o;
   logic             s_stb_o, s_we_o;
   logic [3:0]       s_sel_o;
   logic [31:0]      s_adr_o, s_dat_o;
   logic [NS-1:0]    s_ack_i;
   logic [NS*32-1:0] s_dat_i;
`ifdef WB_BUS_ERRLOG_EN
   logic [15:0]      err_cnt_o;
   logic [31:0]      err_adr_o;
`endif

   int errors = 0;
   int checks = 0;
   logic [31:0] sdat [NS];

   always #5 clk = ~clk;

   wb_bus_ctrl #(
      .NS      (NS),
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .m_cyc_i (m_cyc_i),
      .m_stb_i (m_stb_i),
      .m_we_i  (m_we_i),
      .m_sel_i (m_sel_i),
      .m_adr_i (m_adr_i),
      .m_dat_i (m_dat_i),
      .m_ack_o (m_ack_o),
      .m_err_o (m_err_o),
      .m_dat_o (m_dat_o),
      .s_cyc_o (s_cyc_o),
      .s_stb_o (s_stb_o),
      .s_we_o  (s_we_o),
      .s_sel_o (s_sel_o),
      .s_adr_o (s_adr_o),
      .s_dat_o (s_dat_o),
      .s_ack_i (s_ack_i),
      .s_dat_i (s_dat_i)
`ifdef WB_BUS_ERRLOG_EN
      ,
      .err_cnt_o (err_cnt_o),
      .err_adr_o (err_adr_o)
`endif
   );

   typedef struct {
      string         name;
      logic [31:0]   adr;
      int            ack_at;   // BUSY cycle (1-based) in which the slave ACKs; 0 = never
      logic [NS-1:0] stray;    // ACKs from non-selected slaves
      int            exp_cyc;  // negedge index (after request) where m_ack_o is seen
      logic          exp_err;
      logic [31:0]   exp_dat;
      logic [NS-1:0] exp_scyc;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int lowest_sel(input logic [31:0] adr);
      for (int i = 0; i < NS; i++) begin
         if (adr[31-i]) return i;
      end
      return -1;
   endfunction

   task automatic drive_sdat();
      for (int i = 0; i < NS; i++) s_dat_i[32*i +: 32] = sdat[i];
   endtask

   // Issues one request from a negedge and follows it until m_ack_o.
   task automatic run_txn(input string nm, input logic [31:0] adr, input int ack_at,
                          input logic [NS-1:0] stray, input int exp_cyc, input logic exp_err,
                          input logic [31:0] exp_dat, input logic [NS-1:0] exp_scyc);
      int seen = 0;
      drive_sdat();
      m_cyc_i = 1'b1;
      m_stb_i = 1'b1;
      m_adr_i = adr;
      m_we_i  = 1'($urandom);
      m_sel_i = 4'($urandom);
      m_dat_i = $urandom;
      s_ack_i = stray;
      for (int n = 1; n <= exp_cyc + 3 && seen == 0; n++) begin
         @(negedge clk);
         if (m_ack_o) begin
            seen = n;
            chk({nm, " ack_cycle"}, 32'(n), 32'(exp_cyc));
            chk({nm, " err"}, {31'd0, m_err_o}, {31'd0, exp_err});
            chk({nm, " dat"}, m_dat_o, exp_dat);
            chk({nm, " scyc_resp"}, 32'(s_cyc_o), 32'd0);
         end else begin
            chk({nm, " scyc"}, 32'(s_cyc_o), (n < exp_cyc) ? 32'(exp_scyc) : 32'd0);
            chk({nm, " sstb"}, {31'd0, s_stb_o},
                {31'd0, (exp_scyc != '0) && (n < exp_cyc)});
            chk({nm, " sadr"}, s_adr_o, adr);
            s_ack_i = (n == ack_at) ? (stray | exp_scyc) : stray;
         end
      end
      if (seen == 0) begin
         checks++;
         errors++;
         $display("FAIL %s no_ack: got none expected ack at cycle %0d", nm, exp_cyc);
      end
      m_cyc_i = 1'b0;
      m_stb_i = 1'b0;
      s_ack_i = '0;
      @(negedge clk);
      chk({nm, " ack_pulse"}, {31'd0, m_ack_o}, 32'd0);
   endtask

   vec_t vecs [6];

   initial begin
      logic [31:0]   adr;
      int            sel, ack_at, exp_cyc;
      logic          exp_err;
      logic [31:0]   exp_dat;
      logic [NS-1:0] oh, stray;

      vecs[0] = '{"uart_read",   32'h2000_0004, 3,  6'b000000, 4,           1'b0, 32'h0000_0055, 6'b000100};
      vecs[1] = '{"unmapped",    32'h0000_1000, 0,  6'b000000, 1,           1'b1, 32'hDEADBEEF, 6'b000000};
      vecs[2] = '{"timeout",     32'h8000_0000, 0,  6'b000000, TIMEOUT + 2, 1'b1, 32'hDEADBEEF, 6'b000001};
      vecs[3] = '{"ack_at_to",   32'h8000_0000, TIMEOUT + 1, 6'b000000, TIMEOUT + 2, 1'b0, 32'h5A00_0000, 6'b000001};
      vecs[4] = '{"priority",    32'hC000_0000, 2,  6'b001000, 3,           1'b0, 32'h5A00_0000, 6'b000001};
      vecs[5] = '{"slave5",      32'h0400_0000, 1,  6'b000010, 2,           1'b0, 32'h5A00_0005, 6'b100000};

      rst_n   = 1'b0;
      m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0;
      m_sel_i = 4'h0; m_adr_i = 32'h0; m_dat_i = 32'h0;
      s_ack_i = '0;   s_dat_i = '0;
      for (int i = 0; i < NS; i++) sdat[i] = 32'h5A00_0000 | 32'(i);
      sdat[2] = 32'h0000_0055;
      repeat (2) @(negedge clk);
      chk("rst m_ack", {31'd0, m_ack_o}, 32'd0);
      chk("rst m_err", {31'd0, m_err_o}, 32'd0);
      chk("rst m_dat", m_dat_o, 32'd0);
      chk("rst s_cyc", 32'(s_cyc_o), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed vectors.
      for (int v = 0; v < 6; v++) begin
         run_txn(vecs[v].name, vecs[v].adr, vecs[v].ack_at, vecs[v].stray, vecs[v].exp_cyc,
                 vecs[v].exp_err, vecs[v].exp_dat, vecs[v].exp_scyc);
      end

      // Abort: m_cyc_i falls in BUSY.
      m_cyc_i = 1'b1; m_stb_i = 1'b1; m_adr_i = 32'h2000_0000;
      repeat (2) @(negedge clk);
      chk("abort scyc_before", 32'(s_cyc_o), 32'h0000_0004);
      m_cyc_i = 1'b0; m_stb_i = 1'b0;
      #1;
      chk("abort scyc_same_cycle", 32'(s_cyc_o), 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("abort no_ack", {31'd0, m_ack_o}, 32'd0);
      end
      run_txn("after_abort", 32'h4000_0000, 1, 6'b000000, 2, 1'b0, sdat[1], 6'b000010);

      // Reset in BUSY; m_dat_o currently holds slave 1 data.
      m_cyc_i = 1'b1; m_stb_i = 1'b1; m_adr_i = 32'h8000_0000;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rstbusy m_ack", {31'd0, m_ack_o}, 32'd0);
      chk("rstbusy m_err", {31'd0, m_err_o}, 32'd0);
      chk("rstbusy m_dat", m_dat_o, 32'd0);
      chk("rstbusy s_cyc", 32'(s_cyc_o), 32'd0);
      chk("rstbusy s_stb", {31'd0, s_stb_o}, 32'd0);
      m_cyc_i = 1'b0; m_stb_i = 1'b0;
      @(negedge clk);
      chk("rstbusy no_ack", {31'd0, m_ack_o}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Randomized transactions against the cycle-count model.
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < NS; i++) sdat[i] = $urandom;
         adr = $urandom;
         if ($urandom_range(0, 3) == 0) adr[31:26] = 6'b000000;
         sel    = lowest_sel(adr);
         ack_at = $urandom_range(1, TIMEOUT + 3);
         oh     = (sel >= 0) ? NS'(1 << sel) : '0;
         stray  = NS'($urandom) & ~oh;
         if (sel < 0) begin
            exp_cyc = 1;           exp_err = 1'b1; exp_dat = 32'hDEADBEEF;
         end else if (ack_at <= TIMEOUT + 1) begin
            exp_cyc = ack_at + 1;  exp_err = 1'b0; exp_dat = sdat[sel];
         end else begin
            exp_cyc = TIMEOUT + 2; exp_err = 1'b1; exp_dat = 32'hDEADBEEF;
         end
         run_txn("rand", adr, ack_at, stray, exp_cyc, exp_err, exp_dat, oh);
      end

`ifdef WB_BUS_ERRLOG_EN
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("errlog rst cnt", 32'(err_cnt_o), 32'd0);
      run_txn("elog1", 32'h0000_1000, 0, '0, 1, 1'b1, 32'hDEADBEEF, '0);
      run_txn("elog2", 32'h0000_2000, 0, '0, 1, 1'b1, 32'hDEADBEEF, '0);
      run_txn("elog3", 32'h0123_4567, 0, '0, 1, 1'b1, 32'hDEADBEEF, '0);
      chk("errlog cnt", 32'(err_cnt_o), 32'd3);
      chk("errlog adr", err_adr_o, 32'h0123_4567);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
